// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the RAM arbiter and the per-core cache blocks.
package cpu_types_pkg;

  localparam int unsigned WORD_W  = 32;
  // Core index width; supports up to 16 cores.
  localparam int unsigned CPUID_W = 4;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [CPUID_W-1:0] cpuid_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef enum logic {CLS_I, CLS_D} req_class_t;

  typedef struct packed {
    cpuid_t     cpu;
    req_class_t cls;
  } arb_grant_t;

  // Core index following cpu, wrapping at n cores.
  function automatic cpuid_t next_cpu(cpuid_t cpu, int unsigned n);
    if (int'(cpu) + 1 >= int'(n)) return '0;
    return cpu + cpuid_t'(1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: selects the first asserted request at or above start, wrapping modulo N.
module rr_picker
  import cpu_types_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  cpuid_t       start,
  output logic [N-1:0] onehot,
  output logic         valid
);

  logic [N-1:0]   rot;
  logic [N-1:0]   pick;
  logic [2*N-1:0] spread;

  // Rotate so start sits at bit 0, pick the lowest set bit, rotate the pick back.
  always_comb begin
    rot   = N'({req, req} >> start);
    pick  = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        pick[k] = 1'b1;
        valid   = 1'b1;
      end
    end
    spread = {{N{1'b0}}, pick} << start;
    onehot = spread[N-1:0] | spread[2*N-1:N];
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port among CPUS cores (icache + dcache each).
// Data requests beat instruction requests; round-robin within each class.
// A grant is held for the whole block transfer.
// Optional watchdog: define ARB_WATCHDOG_EN.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS        = 2,
  parameter int unsigned BLOCK_WORDS = 2,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] iREN,
  input  word_t           iaddr  [CPUS],
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  word_t           daddr  [CPUS],
  input  word_t           dstore [CPUS],
  output logic [CPUS-1:0] iwait,
  output logic [CPUS-1:0] dwait,
  output word_t           iload  [CPUS],
  output word_t           dload  [CPUS],
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore,
  input  word_t           ramload,
  input  ramstate_t       ramstate,
  output logic            arb_timeout
);

  localparam int unsigned BEAT_W = $clog2(BLOCK_WORDS + 1);

  arb_state_t        state, state_n;
  arb_grant_t        grant, grant_n;
  cpuid_t            rr, rr_n;
  logic [BEAT_W-1:0] beat, beat_n;

  logic [CPUS-1:0] d_onehot, i_onehot;
  logic            d_valid, i_valid;
  cpuid_t          d_cpu, i_cpu;

  logic  g_ren, g_wen, g_active;
  word_t g_addr, g_store;
  logic  in_grant, access, last_beat, wdog_fire;

  rr_picker #(.N(CPUS)) u_dpick (
    .req    (dREN | dWEN),
    .start  (rr),
    .onehot (d_onehot),
    .valid  (d_valid)
  );

  rr_picker #(.N(CPUS)) u_ipick (
    .req    (iREN),
    .start  (rr),
    .onehot (i_onehot),
    .valid  (i_valid)
  );

  // Encode the one-hot picks into core indices.
  always_comb begin
    d_cpu = '0;
    i_cpu = '0;
    for (int unsigned c = 0; c < CPUS; c++) begin
      if (d_onehot[c]) d_cpu = cpuid_t'(c);
      if (i_onehot[c]) i_cpu = cpuid_t'(c);
    end
  end

  // Mux the granted requester's enables, address and data; write wins over read.
  always_comb begin
    g_ren   = 1'b0;
    g_wen   = 1'b0;
    g_addr  = '0;
    g_store = '0;
    for (int unsigned c = 0; c < CPUS; c++) begin
      if (grant.cpu == cpuid_t'(c)) begin
        if (grant.cls == CLS_D) begin
          g_ren   = dREN[c] & ~dWEN[c];
          g_wen   = dWEN[c];
          g_addr  = daddr[c];
          g_store = dstore[c];
        end else begin
          g_ren  = iREN[c];
          g_addr = iaddr[c];
        end
      end
    end
  end

  assign g_active  = g_ren | g_wen;
  assign in_grant  = (state == GRANT);
  assign access    = in_grant && (ramstate == ACCESS);
  assign last_beat = access && ((grant.cls == CLS_I) || (beat == BEAT_W'(BLOCK_WORDS - 1)));

  assign ramREN   = in_grant & g_ren;
  assign ramWEN   = in_grant & g_wen;
  assign ramaddr  = in_grant ? g_addr  : '0;
  assign ramstore = in_grant ? g_store : '0;

  // Only the granted requester sees wait low, and only on an ACCESS beat.
  always_comb begin
    iwait = '1;
    dwait = '1;
    for (int unsigned c = 0; c < CPUS; c++) begin
      if (access && grant.cpu == cpuid_t'(c)) begin
        if (grant.cls == CLS_D) dwait[c] = 1'b0;
        else                    iwait[c] = 1'b0;
      end
    end
  end

  // Read data is broadcast to every core.
  always_comb begin
    for (int unsigned c = 0; c < CPUS; c++) begin
      iload[c] = ramload;
      dload[c] = ramload;
    end
  end

  // Next-state: pick a requester in IDLE, count beats and release in GRANT.
  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_n    = rr;
    beat_n  = beat;
    unique case (state)
      IDLE: begin
        if (d_valid) begin
          grant_n = '{cpu: d_cpu, cls: CLS_D};
          beat_n  = '0;
          state_n = GRANT;
        end else if (i_valid) begin
          grant_n = '{cpu: i_cpu, cls: CLS_I};
          beat_n  = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!g_active || last_beat || wdog_fire) begin
          state_n = IDLE;
          rr_n    = next_cpu(grant.cpu, CPUS);
          beat_n  = '0;
        end else if (access) begin
          beat_n = beat + BEAT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      grant <= '0;
      rr    <= '0;
      beat  <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      rr    <= rr_n;
      beat  <= beat_n;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog;
  logic              timeout_q;

  // Fires on the WDOG_CYCLES-th consecutive non-ACCESS cycle of a grant.
  assign wdog_fire   = in_grant && !access && (wdog == WDOG_W'(WDOG_CYCLES - 1));
  assign arb_timeout = timeout_q;

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!in_grant || access || wdog_fire) wdog <= '0;
      else                                  wdog <= wdog + WDOG_W'(1);
      if (wdog_fire) timeout_q <= 1'b1;
    end
  end
`else
  assign wdog_fire   = 1'b0;
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// transaction-level reference model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned CPUS = 2;
  localparam int unsigned BW   = 2;
  localparam int unsigned WD   = 64;

  logic            CLK = 1'b0;
  logic            nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  word_t           iaddr [CPUS], daddr [CPUS], dstore [CPUS], iload [CPUS], dload [CPUS];
  logic            ramREN, ramWEN, arb_timeout;
  word_t           ramaddr, ramstore, ramload;
  ramstate_t       ramstate;

  int checks   = 0;
  int failures = 0;

  // Reference model: current owner as plain integers.
  bit m_busy, m_d, m_to;
  int m_cpu, m_beats, m_rr, m_wd;

  int dlog[$];
  int iw0_cnt;

  always #5 CLK = ~CLK;

  ram_arbiter #(.CPUS(CPUS), .BLOCK_WORDS(BW), .WDOG_CYCLES(WD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_timeout(arb_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_d = 0; m_to = 0; m_cpu = 0; m_beats = 0; m_rr = 0; m_wd = 0;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    for (int c = 0; c < CPUS; c++) begin
      iaddr[c] = '0; daddr[c] = '0; dstore[c] = '0;
    end
    ramload  = '0;
    ramstate = FREE;
  endtask

  task automatic check_outputs();
    logic            e_ren, e_wen;
    word_t           e_addr, e_store;
    logic [CPUS-1:0] e_iw, e_dw;
    e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; e_iw = '1; e_dw = '1;
    if (m_busy) begin
      if (m_d) begin
        e_wen   = dWEN[m_cpu];
        e_ren   = dREN[m_cpu] && !dWEN[m_cpu];
        e_addr  = daddr[m_cpu];
        e_store = dstore[m_cpu];
        if (ramstate == ACCESS) e_dw[m_cpu] = 1'b0;
      end else begin
        e_ren  = iREN[m_cpu];
        e_addr = iaddr[m_cpu];
        if (ramstate == ACCESS) e_iw[m_cpu] = 1'b0;
      end
    end
    chk("ramREN",   64'(ramREN),   64'(e_ren));
    chk("ramWEN",   64'(ramWEN),   64'(e_wen));
    chk("ramaddr",  64'(ramaddr),  64'(e_addr));
    chk("ramstore", 64'(ramstore), 64'(e_store));
    chk("iwait",    64'(iwait),    64'(e_iw));
    chk("dwait",    64'(dwait),    64'(e_dw));
    chk("iload1",   64'(iload[1]), 64'(ramload));
    chk("dload0",   64'(dload[0]), 64'(ramload));
    chk("arb_timeout", 64'(arb_timeout), 64'(m_to));
  endtask

  // Model update at a rising edge, from the inputs held across it.
  task automatic advance();
    bit found, acc, act, done;
    int c;
    found = 0;
    if (!m_busy) begin
      for (int k = 0; k < CPUS; k++) begin
        c = (m_rr + k) % CPUS;
        if (!found && (dREN[c] || dWEN[c])) begin found = 1; m_cpu = c; m_d = 1; end
      end
      for (int k = 0; k < CPUS; k++) begin
        c = (m_rr + k) % CPUS;
        if (!found && iREN[c]) begin found = 1; m_cpu = c; m_d = 0; end
      end
      if (found) begin m_busy = 1; m_beats = 0; m_wd = 0; end
    end else begin
      acc  = (ramstate == ACCESS);
      act  = m_d ? (dREN[m_cpu] || dWEN[m_cpu]) : iREN[m_cpu];
      done = !act;
      if (acc) begin
        m_beats++;
        m_wd = 0;
        if (m_beats == (m_d ? BW : 1)) done = 1;
      end
`ifdef ARB_WATCHDOG_EN
      else begin
        m_wd++;
        if (m_wd == WD) begin m_to = 1; done = 1; end
      end
`endif
      if (done) begin m_busy = 0; m_rr = (m_cpu + 1) % CPUS; end
    end
  endtask

  // One clock: check mid-cycle, update the model at the edge, return 1 unit after it.
  task automatic cycle();
    @(negedge CLK);
    check_outputs();
    for (int c = 0; c < CPUS; c++) if (dwait[c] === 1'b0) dlog.push_back(c);
    if (iwait[0] === 1'b0) iw0_cnt++;
    @(posedge CLK);
    advance();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ren"},  64'(ramREN),  64'd0);
    chk({tag, "_wen"},  64'(ramWEN),  64'd0);
    chk({tag, "_addr"}, 64'(ramaddr), 64'd0);
    chk({tag, "_iw"},   64'(iwait),   64'(2'b11));
    chk({tag, "_dw"},   64'(dwait),   64'(2'b11));
    chk({tag, "_to"},   64'(arb_timeout), 64'd0);
  endtask

  task automatic release_reset();
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int exp_log[6];
    exp_log = '{0, 0, 1, 1, 0, 0};
    clear_inputs();
    model_reset();
    nRST = 1'b0;
    #12;
    chk_reset_outputs("reset");
    release_reset();

    // Idle.
    for (int n = 0; n < 10; n++) cycle();
    chk_reset_outputs("idle");

    // Single icache fetch with two BUSY cycles.
    iw0_cnt = 0;
    iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = BUSY;
    cycle();
    chk("t2_ren", 64'(ramREN), 64'd1);
    chk("t2_addr", 64'(ramaddr), 64'h40);
    cycle();
    ramstate = ACCESS;
    cycle();
    iREN[0] = 1'b0; ramstate = FREE;
    chk("t2_idle_ren", 64'(ramREN), 64'd0);
    cycle();
    chk("t2_iwait_pulses", 64'(iw0_cnt), 64'd1);

    // Data priority: cpu1 write beats cpu0 fetch, held for two beats.
    iREN[0] = 1'b1; iaddr[0] = 32'h100;
    dWEN[1] = 1'b1; daddr[1] = 32'h200; dstore[1] = 32'hDEAD;
    ramstate = ACCESS;
    cycle();
    chk("t3_wen", 64'(ramWEN), 64'd1);
    chk("t3_addr", 64'(ramaddr), 64'h200);
    chk("t3_store", 64'(ramstore), 64'hDEAD);
    cycle();
    chk("t3_hold_addr", 64'(ramaddr), 64'h200);
    cycle();
    dWEN[1] = 1'b0;
    chk("t3_gap_ren", 64'(ramREN), 64'd0);
    cycle();
    chk("t3_fetch_ren", 64'(ramREN), 64'd1);
    chk("t3_fetch_addr", 64'(ramaddr), 64'h100);
    cycle();
    iREN[0] = 1'b0;
    cycle();

    // Round-robin between two continuous dcache readers, from a fresh reset.
    nRST = 1'b0; model_reset(); #1;
    release_reset();
    dlog.delete();
    dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20; ramstate = ACCESS;
    for (int n = 0; n < 12; n++) cycle();
    chk("t4_log_len", 64'(dlog.size() >= 6), 64'd1);
    for (int k = 0; k < 6; k++)
      if (k < dlog.size()) chk($sformatf("t4_beat%0d", k), 64'(dlog[k]), 64'(exp_log[k]));
    dREN = '0;
    cycle();

    // Early drop after beat 1, then rr check, then reset mid-burst.
    dREN[1] = 1'b1; daddr[1] = 32'h300; ramstate = ACCESS;
    cycle();
    cycle();
    dREN[1] = 1'b0; ramstate = BUSY;
    #1;
    chk("t5_drop_ren", 64'(ramREN), 64'd0);
    cycle();
    dREN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500; ramstate = ACCESS;
    cycle();
    chk("t5_rr_addr", 64'(ramaddr), 64'h400);
    cycle();
    #2;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    model_reset();
    release_reset();

`ifdef ARB_WATCHDOG_EN
    // Watchdog: RAM stuck BUSY.
    dREN[0] = 1'b1; daddr[0] = 32'h600; ramstate = BUSY;
    for (int n = 0; n < 60; n++) cycle();
    chk("t6_before", 64'(arb_timeout), 64'd0);
    for (int n = 0; n < 8; n++) cycle();
    chk("t6_fired", 64'(arb_timeout), 64'd1);
    dREN = '0; ramstate = FREE;
    cycle();
    nRST = 1'b0; model_reset(); #1;
    release_reset();
`endif

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(7) == 0) iREN[c] = ~iREN[c];
        if ($urandom_range(7) == 0) dREN[c] = ~dREN[c];
        if ($urandom_range(11) == 0) dWEN[c] = ~dWEN[c];
        iaddr[c]  = $urandom;
        daddr[c]  = $urandom;
        dstore[c] = $urandom;
      end
      ramload = $urandom;
      case ($urandom_range(5))
        0:       ramstate = BUSY;
        1:       ramstate = FREE;
        2:       ramstate = ERROR;
        default: ramstate = ACCESS;
      endcase
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
